// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the core's load/store interface. One request at a time
// is taken over a valid/ready request channel, the access is carried out
// after WAIT_STATES extra cycles, and the load data plus an error flag are
// returned over a valid/ready response channel.
//
// Parameters:
//   ADDR_WIDTH  - word-address bits; storage is 2^ADDR_WIDTH 32-bit words.
//                 Must be 29 or less so the out-of-range check has bits to test.
//   WAIT_STATES - extra cycles between request accept and response (0..15).
//   INIT_FILE   - hex image path; not read by this model.
//
// Storage starts out uninitialised. Handshake behaviour and timing do not
// depend on any build macro.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous, active-high reset
//   req_valid    - request present
//   req_ready    - responder can accept a request (IDLE and not in reset)
//   req_write    - 1 = store, 0 = load
//   req_addr     - byte address
//   req_size     - 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned - loads only: 1 = zero-extend, 0 = sign-extend
//   req_wdata    - store data, LSB-aligned
//   rsp_valid    - response present
//   rsp_ready    - initiator accepts the response
//   rsp_rdata    - load data extended to 32 bits; 0 for stores and errors
//   rsp_error    - access faulted
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int    ADDR_WIDTH  = 10,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = "dmem_init.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Storage: never reset, only written on a committed, fault-free store.
    logic [31:0] mem [DEPTH];

    // Registered state and latched request.
    state_t      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic        write_q,     write_d;
    logic [31:0] addr_q,      addr_d;
    logic [1:0]  size_q,      size_d;
    logic        unsigned_q,  unsigned_d;
    logic [31:0] wdata_q,     wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    // Access decode of the latched request.
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  acc_error;
    logic [31:0]           rd_word;
    logic [31:0]           load_data;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_we;

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign rd_word  = mem[word_idx];

    // Fault detection on the latched request: illegal size, misalignment,
    // or any address bit set above the implemented storage.
    always_comb begin
        acc_error = 1'b0;
        if (size_q == 2'b11) begin
            acc_error = 1'b1;
        end
        if ((size_q == SIZE_HALF) && addr_q[0]) begin
            acc_error = 1'b1;
        end
        if ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00)) begin
            acc_error = 1'b1;
        end
        if ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0) begin
            acc_error = 1'b1;
        end
    end

    // Load path: pick the addressed byte or half out of the stored word and
    // extend it. Word loads return the word as-is and ignore the unsigned flag.
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = rd_word[8*addr_q[1:0] +: 8];
        sel_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (size_q)
            SIZE_BYTE: load_data = unsigned_q ? {24'd0, sel_byte}
                                              : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: load_data = unsigned_q ? {16'd0, sel_half}
                                              : {{16{sel_half[15]}}, sel_half};
            default:   load_data = rd_word;
        endcase
    end

    // Store path: replicate the LSB-aligned data onto every lane and let the
    // byte enables decide which lanes actually change.
    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = wdata_q;
        case (size_q)
            SIZE_BYTE: begin
                mem_be    = 4'b0001 << addr_q[1:0];
                mem_wdata = {4{wdata_q[7:0]}};
            end
            SIZE_HALF: begin
                mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{wdata_q[15:0]}};
            end
            SIZE_WORD: begin
                mem_be    = 4'b1111;
                mem_wdata = wdata_q;
            end
            default: begin
                mem_be    = 4'b0000;
                mem_wdata = wdata_q;
            end
        endcase
    end

    // Next-state logic. Every accepted request goes through WAIT with the
    // counter loaded to WAIT_STATES; the access commits on the edge where the
    // counter is already zero, which makes WAIT_STATES = 0 a one-cycle
    // latency. Reset suppresses the commit write so an aborted store never
    // reaches the storage.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_d    = req_write;
                    addr_d     = req_addr;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    cnt_d      = 4'(WAIT_STATES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    mem_we      = write_q && !acc_error && !rst;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = acc_error;
                    rsp_rdata_d = (write_q || acc_error) ? 32'd0 : load_data;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            wdata_q     <= wdata_d;
        end
    end

    // Storage write port with per-lane enables; lanes not enabled keep
    // their previous contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders (WAIT_STATES = 1, 3 and 0) share one request stream so the
// same directed vectors exercise each latency. Expected responses are queued
// per instance when a request is issued; a monitor pops and compares them
// when a response handshake is seen, and also watches latency, reset values,
// backpressure stability and req_ready around handshakes.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NDUT = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic [NDUT-1:0] req_ready_w;
    logic [NDUT-1:0] rsp_valid_w;
    logic [NDUT-1:0] rsp_error_w;
    logic [31:0]     rsp_rdata_w [NDUT];

    exp_t exp_q [NDUT][$];

    int vectors;
    int miscompares;
    int cyc;

    function automatic int waitStatesOf(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(
            .ADDR_WIDTH (10),
            .WAIT_STATES(waitStatesOf(g))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid),
            .req_ready   (req_ready_w[g]),
            .req_write   (req_write),
            .req_addr    (req_addr),
            .req_size    (req_size),
            .req_unsigned(req_unsigned),
            .req_wdata   (req_wdata),
            .rsp_valid   (rsp_valid_w[g]),
            .rsp_ready   (rsp_ready),
            .rsp_rdata   (rsp_rdata_w[g]),
            .rsp_error   (rsp_error_w[g])
        );
    end

    // Free-running clock and a count of rising edges for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Single comparison point; only the monitor calls it.
    task automatic checkOutput(input string name, input int g,
                               input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d (ws=%0d): got %h, expected %h",
                     name, g, waitStatesOf(g), act, req);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic        rst_prev;
        logic [NDUT-1:0] valid_prev;
        logic [NDUT-1:0] hold_prev;
        logic [NDUT-1:0] hs_prev;
        logic [31:0] rdata_prev [NDUT];
        logic        err_prev   [NDUT];
        int          acc_edge   [NDUT];
        exp_t        e;
        rst_prev   = 1'b0;
        valid_prev = '0;
        hold_prev  = '0;
        hs_prev    = '0;
        for (int g = 0; g < NDUT; g++) begin
            rdata_prev[g] = 32'd0;
            err_prev[g]   = 1'b0;
            acc_edge[g]   = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (rst_prev) begin
                    checkOutput("reset_req_ready", g, {31'd0, req_ready_w[g]}, {31'd0, !rst});
                    checkOutput("reset_rsp_valid", g, {31'd0, rsp_valid_w[g]}, 32'd0);
                    checkOutput("reset_rsp_rdata", g, rsp_rdata_w[g], 32'd0);
                    checkOutput("reset_rsp_error", g, {31'd0, rsp_error_w[g]}, 32'd0);
                end
                if (req_valid && req_ready_w[g]) begin
                    acc_edge[g] = cyc + 1;
                end
                if (rsp_valid_w[g] && !valid_prev[g] && !rst) begin
                    checkOutput("latency", g, 32'(cyc - acc_edge[g]), 32'(1 + waitStatesOf(g)));
                end
                if (hold_prev[g] && !rst) begin
                    checkOutput("hold_valid", g, {31'd0, rsp_valid_w[g]}, 32'd1);
                    checkOutput("hold_rdata", g, rsp_rdata_w[g], rdata_prev[g]);
                    checkOutput("hold_error", g, {31'd0, rsp_error_w[g]}, {31'd0, err_prev[g]});
                end
                if (rsp_valid_w[g]) begin
                    checkOutput("busy_req_ready", g, {31'd0, req_ready_w[g]}, 32'd0);
                end
                if (hs_prev[g] && !rst) begin
                    checkOutput("post_hs_req_ready", g, {31'd0, req_ready_w[g]}, 32'd1);
                end
                if (rsp_valid_w[g] && rsp_ready && !rst) begin
                    if (exp_q[g].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_rsp dut%0d: got rsp_valid=1, expected no response", g);
                    end else begin
                        e = exp_q[g].pop_front();
                        checkOutput("rsp_rdata", g, rsp_rdata_w[g], e.rdata);
                        checkOutput("rsp_error", g, {31'd0, rsp_error_w[g]}, {31'd0, e.err});
                    end
                end
                hold_prev[g]  = rsp_valid_w[g] && !rsp_ready;
                hs_prev[g]    = rsp_valid_w[g] && rsp_ready && !rst;
                valid_prev[g] = rsp_valid_w[g];
                rdata_prev[g] = rsp_rdata_w[g];
                err_prev[g]   = rsp_error_w[g];
            end
            rst_prev = rst;
        end
    end

    // Wait (bounded) until every responder is idle and ready.
    task automatic waitAllReady();
        int n;
        n = 0;
        while (req_ready_w != '1) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                $display("[TB] FAIL wait_ready: got req_ready=%b, expected %b", req_ready_w, {NDUT{1'b1}});
                $fatal(1, "[TB] timeout waiting for req_ready");
            end
        end
    endtask

    task automatic waitAllValid();
        int n;
        n = 0;
        while (rsp_valid_w != '1) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                $display("[TB] FAIL wait_valid: got rsp_valid=%b, expected %b", rsp_valid_w, {NDUT{1'b1}});
                $fatal(1, "[TB] timeout waiting for rsp_valid");
            end
        end
    endtask

    // Issue one request to all responders and queue its expected response.
    // hold > 0 keeps rsp_ready low for that many cycles once all responses
    // are presented.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns,
                                 input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int hold);
        exp_t e;
        waitAllReady();
        e.rdata = exp_rdata;
        e.err   = exp_err;
        for (int g = 0; g < NDUT; g++) begin
            exp_q[g].push_back(e);
        end
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        if (hold > 0) begin
            rsp_ready = 1'b0;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (hold > 0) begin
            waitAllValid();
            repeat (hold) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
        end
    endtask

    localparam logic W = 1'b1;
    localparam logic R = 1'b0;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SX = 2'b11;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'd0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Word store then load.
        applyStimulus(W, 32'h10, SW, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        applyStimulus(R, 32'h10, SW, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // Byte store into a cleared word, then sign handling.
        applyStimulus(W, 32'h0, SW, 1'b0, 32'h00000000, 32'h0, 1'b0, 0);
        applyStimulus(W, 32'h2, SB, 1'b0, 32'h00000080, 32'h0, 1'b0, 0);
        applyStimulus(R, 32'h0, SW, 1'b0, 32'h0, 32'h00800000, 1'b0, 0);
        applyStimulus(R, 32'h2, SB, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        applyStimulus(R, 32'h2, SB, 1'b1, 32'h0, 32'h00000080, 1'b0, 0);

        // Half lanes: upper half replaced, lower half unchanged.
        applyStimulus(W, 32'h4, SW, 1'b0, 32'h12345678, 32'h0, 1'b0, 0);
        applyStimulus(W, 32'h6, SH, 1'b0, 32'h0000A5A5, 32'h0, 1'b0, 0);
        applyStimulus(R, 32'h4, SW, 1'b0, 32'h0, 32'hA5A55678, 1'b0, 0);
        applyStimulus(R, 32'h6, SH, 1'b0, 32'h0, 32'hFFFFA5A5, 1'b0, 0);
        applyStimulus(R, 32'h4, SH, 1'b1, 32'h0, 32'h00005678, 1'b0, 0);
        applyStimulus(R, 32'h7, SB, 1'b0, 32'h0, 32'hFFFFFFA5, 1'b0, 0);

        // Faults: misaligned word, out of range store, illegal size, odd half.
        applyStimulus(R, 32'h3, SW, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus(W, 32'h00001000, SW, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        applyStimulus(R, 32'h0, SW, 1'b0, 32'h0, 32'h00800000, 1'b0, 0);
        applyStimulus(R, 32'h0, SX, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus(W, 32'h5, SH, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, 0);
        applyStimulus(R, 32'h4, SW, 1'b0, 32'h0, 32'hA5A55678, 1'b0, 0);

        // Backpressure: response held for 5 cycles.
        applyStimulus(R, 32'h10, SW, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 5);

        // Reset one cycle after accepting a store: no response, no write.
        applyStimulus(W, 32'h20, SW, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        waitAllReady();
        req_valid = 1'b1;
        req_write = W;
        req_addr  = 32'h20;
        req_size  = SW;
        req_wdata = 32'h11111111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(R, 32'h20, SW, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        waitAllReady();
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
